div_operand_sequencer: RTL and testbench

Front-end stage feeding the iterative 10-bit divider datapath and its controller. Buffers (dividend, divisor) jobs from a valid/ready producer in a small FIFO and issues them one at a time with a start pulse. It holds the operands stable while the divider runs, then captures the quotient on done and presents it downstream through a valid/ready result port. Divide-by-zero jobs are short-circuited and never issued to the divider.

---
 rtl/div_operand_sequencer_pkg.sv | 18 +
 rtl/div_operand_sequencer_sync_fifo.sv | 55 +++++
 rtl/div_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_div_operand_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_operand_sequencer_pkg.sv
// Shared definitions for the divider operand sequencer: sequencer state
// encoding, the divider's native width and the divide-by-zero quotient.
package div_operand_sequencer_pkg;

    localparam int DIV_WIDTH = 10;

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ZDIV  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/div_operand_sequencer_sync_fifo.sv
// Small synchronous FIFO holding packed {dividend, divisor} jobs.
// The head entry is read combinationally so the sequencer can inspect it.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/div_operand_sequencer.sv
// Front end of the iterative divider: queues jobs, issues one at a time
// with a start pulse, holds operands through the run, and returns the
// quotient (or an all-ones divide-by-zero result) on a valid/ready port.
module div_operand_sequencer
    import div_operand_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic             out_dz
);

    localparam logic [WIDTH-1:0] ZQ = {WIDTH{1'b1}};

    seq_state_e             state_q, state_d;
    logic                   push_en;
    logic                   pop_en;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*WIDTH-1:0]     fifo_dout;
    logic [WIDTH-1:0]       head_dividend;
    logic [WIDTH-1:0]       head_divisor;
    // Occupancy is tracked inside the FIFO; full/empty carry all we need.
    logic [$clog2(DEPTH):0] fifo_count_unused;

    // in_ready follows occupancy alone, so a full FIFO never takes a push
    // even when a pop happens in the same cycle.
    assign in_ready = ~fifo_full;
    assign push_en  = in_valid & in_ready;
    assign {head_dividend, head_divisor} = fifo_dout;

    sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .pop   (pop_en),
        .din   ({in_dividend, in_divisor}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and FIFO pop; zero divisors bypass the divider entirely.
    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_d = (head_divisor != '0) ? ST_ISSUE : ST_ZDIV;
            end
            ST_ISSUE: begin
                pop_en  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) state_d = ST_HOLD;
            end
            ST_ZDIV: begin
                pop_en  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign div_start = (state_q == ST_ISSUE);
    assign out_valid = (state_q == ST_HOLD);

    // Operands load as ISSUE is entered so they are already valid alongside
    // the start pulse, then stay frozen until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
            div_dividend <= head_dividend;
            div_divisor  <= head_divisor;
        end
    end

    // Result register; div_done outside WAIT is deliberately ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_quotient <= '0;
            out_dz       <= 1'b0;
        end else if (state_q == ST_WAIT && div_done) begin
            out_quotient <= div_quotient;
            out_dz       <= 1'b0;
        end else if (state_q == ST_ZDIV) begin
            out_quotient <= ZQ;
            out_dz       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench for div_operand_sequencer: behavioural divider with programmable
// latency plus a job scoreboard computing quotients with plain arithmetic.
module tb_div_operand_sequencer;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_dividend = '0;
    logic [W-1:0] in_divisor = '0;
    logic         div_start;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_done;
    logic [W-1:0] div_quotient;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quotient;
    logic         out_dz;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // divider model state
    int           div_lat = 12;
    int           cnt = 0;
    int           done_cyc = -1;
    logic         model_done = 1'b0;
    logic [W-1:0] model_q = '0;
    logic         force_done = 1'b0;
    logic [W-1:0] force_q = '0;

    // expected results in push order: {dz, quotient}
    logic [W:0] exp_q[$];

    assign div_done     = model_done | force_done;
    assign div_quotient = force_done ? force_q : model_q;

    div_operand_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_dz       (out_dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider: div_done pulses div_lat cycles after the start pulse.
    always @(negedge clk) begin
        if (div_start) begin
            cnt     <= div_lat;
            model_q <= div_dividend / div_divisor;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
        model_done <= (!div_start && cnt == 1);
        if (!div_start && cnt == 1) done_cyc <= cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {1'b1, {W{1'b1}}};
        return {1'b0, W'(a / b)};
    endfunction

    // Drives one job until accepted; t is the cycle in which the push occurs.
    task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, output int t);
        int guard = 0;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL push_timeout: in_ready=%0d required 1", in_ready);
        end
        t = cyc;
        exp_q.push_back(ref_result(a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vc);
        int guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        vc = cyc;
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL valid_timeout: out_valid=%0d required 1", out_valid);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, div_start, out_valid, out_dz} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%0d div_start=%0d out_valid=%0d out_dz=%0d required 1 0 0 0",
                     in_ready, div_start, out_valid, out_dz);
        end
        checks++;
        if (div_dividend !== '0 || div_divisor !== '0) begin
            failures++;
            $display("FAIL reset_operands: got %0d/%0d required 0/0", div_dividend, div_divisor);
        end
        checks++;
        if (out_quotient !== '0) begin
            failures++;
            $display("FAIL reset_quotient: got %0d required 0", out_quotient);
        end
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_single();
        int t, sc = -1, vc = -1;
        bit unstable = 0;
        logic [W:0] e;
        div_lat = 12;
        push_job(10'd100, 10'd7, t);
        for (int i = 0; i < 60 && vc < 0; i++) begin
            if (div_start && sc < 0) begin
                sc = cyc;
                checks++;
                if (div_dividend !== 10'd100 || div_divisor !== 10'd7) begin
                    failures++;
                    $display("FAIL single_start_operands: got %0d/%0d required 100/7", div_dividend, div_divisor);
                end
            end else if (sc >= 0 && !out_valid && (div_dividend !== 10'd100 || div_divisor !== 10'd7)) begin
                unstable = 1;
            end
            if (out_valid) vc = cyc;
            else @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (sc != t + 2) begin
            failures++;
            $display("FAIL single_start_latency: start cycle %0d required %0d", sc, t + 2);
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL single_operand_stability: changed=%0d required 0", unstable);
        end
        checks++;
        if (vc != done_cyc + 1) begin
            failures++;
            $display("FAIL single_valid_latency: valid cycle %0d required %0d", vc, done_cyc + 1);
        end
        checks++;
        if (out_quotient !== 10'd14 || out_quotient !== e[W-1:0] || out_dz !== 1'b0) begin
            failures++;
            $display("FAIL single_result: got q=%0d dz=%0d required q=14 dz=0", out_quotient, out_dz);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_valid_drop: out_valid=%0d required 0", out_valid);
        end
    endtask

    task automatic test_zdiv();
        int t, vc = -1;
        bit saw_start = 0;
        push_job(10'd5, 10'd0, t);
        for (int i = 0; i < 20 && vc < 0; i++) begin
            if (div_start) saw_start = 1;
            if (out_valid) vc = cyc;
            else @(negedge clk);
        end
        void'(exp_q.pop_front());
        checks++;
        if (saw_start) begin
            failures++;
            $display("FAIL zdiv_no_start: div_start seen=%0d required 0", saw_start);
        end
        checks++;
        if (vc != t + 3) begin
            failures++;
            $display("FAIL zdiv_latency: valid cycle %0d required %0d", vc, t + 3);
        end
        checks++;
        if (out_quotient !== 10'h3FF || out_dz !== 1'b1) begin
            failures++;
            $display("FAIL zdiv_result: got q=%0h dz=%0d required q=3ff dz=1", out_quotient, out_dz);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int t, vc, a, p = -1;
        bit leaked = 0;
        logic [W-1:0] ja[5];
        logic [W-1:0] jb[5];
        logic [W:0] e;
        div_lat = $urandom_range(3, 8);
        ja = '{10'd1023, 10'd9, 10'd0, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023))};
        jb = '{10'd1, 10'd3, 10'd4, W'($urandom_range(1, 1023)), W'($urandom_range(0, 3))};
        // a zero-divisor blocker parks the sequencer in HOLD
        push_job(W'($urandom_range(0, 1023)), 10'd0, t);
        void'(exp_q.pop_front());
        wait_valid(vc);
        for (int k = 0; k < 4; k++) push_job(ja[k], jb[k], t);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full: in_ready=%0d required 0", in_ready);
        end
        in_valid    = 1'b1;
        in_dividend = ja[4];
        in_divisor  = jb[4];
        for (int i = 0; i < 5; i++) begin
            if (in_ready) leaked = 1;
            @(negedge clk);
        end
        checks++;
        if (leaked) begin
            failures++;
            $display("FAIL b2b_blocked: in_ready went high=%0d required 0", leaked);
        end
        checks++;
        if (out_quotient !== 10'h3FF || out_dz !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_blocker: got q=%0h dz=%0d v=%0d required 3ff 1 1", out_quotient, out_dz, out_valid);
        end
        a = cyc;
        accept();
        for (int i = 0; i < 20 && p < 0; i++) begin
            if (in_ready) p = cyc;
            else @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.push_back(ref_result(ja[4], jb[4]));
        checks++;
        if (p != a + 3) begin
            failures++;
            $display("FAIL b2b_fifth_push: push cycle %0d required %0d", p, a + 3);
        end
        for (int k = 0; k < 5; k++) begin
            wait_valid(vc);
            e = exp_q.pop_front();
            checks++;
            if (out_quotient !== e[W-1:0] || out_dz !== e[W]) begin
                failures++;
                $display("FAIL b2b_result%0d: got q=%0d dz=%0d required q=%0d dz=%0d",
                         k, out_quotient, out_dz, e[W-1:0], e[W]);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept();
        end
    endtask

    task automatic test_hold();
        int t, vc, ac;
        bit drift = 0;
        logic [W:0] e;
        logic [W-1:0] q0;
        logic dz0;
        div_lat = $urandom_range(2, 6);
        push_job(W'($urandom_range(0, 1023)), W'($urandom_range(1, 1023)), t);
        push_job(W'($urandom_range(0, 1023)), W'($urandom_range(1, 1023)), t);
        wait_valid(vc);
        e = exp_q.pop_front();
        q0 = out_quotient;
        dz0 = out_dz;
        checks++;
        if (q0 !== e[W-1:0] || dz0 !== e[W]) begin
            failures++;
            $display("FAIL hold_result: got q=%0d dz=%0d required q=%0d dz=%0d", q0, dz0, e[W-1:0], e[W]);
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_quotient !== q0 || out_dz !== dz0 || div_start !== 1'b0) drift = 1;
            @(negedge clk);
        end
        checks++;
        if (drift) begin
            failures++;
            $display("FAIL hold_stable: changed=%0d required 0", drift);
        end
        ac = cyc;
        accept();
        checks++;
        if (div_start !== 1'b0) begin
            failures++;
            $display("FAIL hold_bubble: div_start=%0d at cycle %0d required 0", div_start, ac + 1);
        end
        @(negedge clk);
        checks++;
        if (div_start !== 1'b1) begin
            failures++;
            $display("FAIL hold_next_issue: div_start=%0d at cycle %0d required 1", div_start, ac + 2);
        end
        wait_valid(vc);
        e = exp_q.pop_front();
        checks++;
        if (out_quotient !== e[W-1:0] || out_dz !== e[W]) begin
            failures++;
            $display("FAIL hold_second: got q=%0d dz=%0d required q=%0d dz=%0d", out_quotient, out_dz, e[W-1:0], e[W]);
        end
        accept();
    endtask

    task automatic test_reset_midwait();
        int t;
        bit leak = 0;
        div_lat = 30;
        for (int k = 0; k < 3; k++)
            push_job(W'($urandom_range(0, 1023)), W'($urandom_range(1, 1023)), t);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if ({in_ready, div_start, out_valid, out_dz} !== 4'b1000 ||
            div_dividend !== '0 || div_divisor !== '0 || out_quotient !== '0) begin
            failures++;
            $display("FAIL midwait_reset: rdy=%0d st=%0d v=%0d dz=%0d op=%0d/%0d q=%0d required 1 0 0 0 0/0 0",
                     in_ready, div_start, out_valid, out_dz, div_dividend, div_divisor, out_quotient);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid || div_start || out_quotient !== '0) leak = 1;
            @(negedge clk);
        end
        checks++;
        if (leak) begin
            failures++;
            $display("FAIL midwait_late_done: activity after reset=%0d required 0", leak);
        end
    endtask

    task automatic test_idle_done();
        int t, vc, sc = -1;
        bit leak = 0;
        force_q    = W'($urandom_range(1, 1023));
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid || div_start || out_quotient !== '0) leak = 1;
            @(negedge clk);
        end
        checks++;
        if (leak) begin
            failures++;
            $display("FAIL idle_done_ignored: activity=%0d required 0", leak);
        end
        div_lat = 3;
        push_job(10'd20, 10'd4, t);
        for (int i = 0; i < 10 && sc < 0; i++) begin
            if (div_start) sc = cyc;
            else @(negedge clk);
        end
        checks++;
        if (sc != t + 2) begin
            failures++;
            $display("FAIL idle_still_idle: start cycle %0d required %0d", sc, t + 2);
        end
        wait_valid(vc);
        void'(exp_q.pop_front());
        checks++;
        if (out_quotient !== 10'd5 || out_dz !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_result: got q=%0d dz=%0d required q=5 dz=0", out_quotient, out_dz);
        end
        accept();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_zdiv();
        test_back_to_back();
        test_hold();
        test_reset_midwait();
        test_idle_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
